// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: groups the request, FIFO-side and output-stream
// signals of the burst reader. The master modport is the reader itself; the
// slave modport is its environment (requester, FIFO and downstream consumer).
interface fifo_burst_reader_if #(
    parameter type T     = logic [7:0],
    parameter int  LEN_W = 8
);
    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    T                 fifo_data;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             out_valid;
    T                 out_data;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic [LEN_W-1:0] beats_left;

    modport master (
        input  req_valid, req_len, fifo_data, fifo_empty, out_ready,
        output req_ready, fifo_pop, out_valid, out_data, out_last, busy, beats_left
    );

    modport slave (
        output req_valid, req_len, fifo_data, fifo_empty, out_ready,
        input  req_ready, fifo_pop, out_valid, out_data, out_last, busy, beats_left
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a requested number of entries from a peek-style
// FIFO and streams them out through a 2-entry skid buffer, flagging the final
// beat with out_last. The pop strobe depends only on registered state and
// fifo_empty, never on out_ready, so the FIFO timing is isolated from the
// consumer while full throughput is kept.
// Optional macro FIFO_BURST_READER_STATS_EN adds a saturating 16-bit
// stall_cycles counter of cycles lost to an empty FIFO.
module fifo_burst_reader #(
    parameter type T     = logic [7:0],
    parameter int  LEN_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fifo_burst_reader_if.master        bus
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [15:0]                stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] pop_cnt_q;
    logic [LEN_W-1:0] beats_left_q;

    // Skid buffer: slot 0 is always the oldest entry.
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    T                 data_q [2];
    T                 data_d [2];
    logic             last_q [2];
    logic             last_d [2];

    logic             pop;
    logic             hs;
    logic             wr_idx;

    assign pop = (state_q == DRAIN) && !bus.fifo_empty &&
                 (pop_cnt_q != '0) && (occ_q != 2'd2);
    assign hs  = (occ_q != 2'd0) && bus.out_ready;

    // A pop lands behind whatever survives this cycle's handshake.
    assign wr_idx = (occ_q == 2'd1) && !hs;
    assign occ_d  = occ_q + 2'(pop) - 2'(hs);

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.fifo_pop   = pop;
    assign bus.beats_left = beats_left_q;
    assign bus.out_valid  = (occ_q != 2'd0);
    assign bus.out_data   = (occ_q != 2'd0) ? data_q[0] : '0;
    assign bus.out_last   = (occ_q != 2'd0) && last_q[0];

    // Next skid contents: shift on handshake, then write the popped entry.
    always_comb begin
        data_d = data_q;
        last_d = last_q;
        if (hs) begin
            data_d[0] = data_q[1];
            last_d[0] = last_q[1];
        end
        if (pop) begin
            data_d[wr_idx] = bus.fifo_data;
            last_d[wr_idx] = (pop_cnt_q == LEN_W'(1));
        end
    end

    // Skid buffer storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= data_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

    // Burst FSM with the pop and beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pop_cnt_q    <= '0;
            beats_left_q <= '0;
        end else begin
            if (hs && (beats_left_q != '0)) begin
                beats_left_q <= beats_left_q - LEN_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && (bus.req_len != '0)) begin
                        state_q      <= DRAIN;
                        pop_cnt_q    <= bus.req_len;
                        beats_left_q <= bus.req_len;
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        pop_cnt_q <= pop_cnt_q - LEN_W'(1);
                        if (pop_cnt_q == LEN_W'(1)) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (hs && last_q[0]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    logic [15:0] stall_cycles_q;
    logic        stall;
    logic        accept;

    assign accept       = (state_q == IDLE) && bus.req_valid;
    assign stall        = (state_q == DRAIN) && bus.fifo_empty &&
                          (pop_cnt_q != '0) && (occ_q != 2'd2);
    assign stall_cycles = stall_cycles_q;

    // Saturating count of cycles a pop was wanted but the FIFO was empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'd0;
        end else if (accept) begin
            stall_cycles_q <= 16'd0;
        end else if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
        end
    end
`endif

endmodule
